// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux scan controller.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mux_scan_pkg

// File: rtl/mux_scan_ctrl.sv
// Steps an external 8:1 mux through all channels, samples its output per
// channel and presents the assembled word with a one-cycle valid pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mux_y,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             valid,
    output logic [NUM_CH-1:0] data
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_CH - 1);

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NUM_CH-1:0]   sh;
    logic [NUM_CH-1:0]   sh_next;

    // Shadow word with the current channel's sample merged in, so the last
    // channel lands in data on the same edge that valid rises.
    always_comb begin
        sh_next      = sh;
        sh_next[sel] = mux_y;
    end

    // Scan FSM with registered outputs; abort overrides sampling/completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            hold_cnt <= '0;
            sh       <= '0;
            data     <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    sel      <= '0;
                    hold_cnt <= '0;
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state    <= IDLE;
                        sel      <= '0;
                        hold_cnt <= '0;
                        sh       <= '0;
                        busy     <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        sh       <= sh_next;
                        if (sel == SEL_LAST) begin
                            state <= DONE;
                            sel   <= '0;
                            data  <= sh_next;
                            busy  <= 1'b0;
                            valid <= 1'b1;
                        end else begin
                            sel <= sel + SEL_W'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    sel      <= '0;
                    hold_cnt <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule : mux_scan_ctrl

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential scan controller that sits directly upstream and downstream of the 8:1 channel multiplexer. It drives the multiplexer's 3-bit select, samples the multiplexer output once per channel, and assembles the eight samples into a parallel word. A start/valid handshake links it to the consuming logic, and an optional per-channel settle delay is included.

## Interface
- `SETTLE`, default 0: extra hold cycles per channel before sampling; range 0–15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a scan; sampled only in IDLE or DONE.
- `abort`  in  1: cancel an in-progress scan.
- `mux_y`  in  1: multiplexer output; combinational from `sel`.
- `sel`  out  3: channel select to the multiplexer, as {s2,s1,s0}.
- `busy`  out  1: high while scanning.
- `valid`  out  1: one-cycle pulse when `data` holds a new complete word.
- `data`  out  8: `data[k]` is the sample of channel k from the last completed scan.

## Operation
- States:
  - IDLE: `sel`=0, `busy`=0.
  - SCAN: `busy`=1; `sel` steps through channels 0..7 in order.
  - DONE: `valid`=1 for exactly one cycle.
- IDLE transitions:
  - `start`=1 → SCAN with `sel`=0 and hold counter=0.
  - Otherwise stay in IDLE.
- SCAN behaviour:
  - Each channel is held for SETTLE+1 cycles.
  - On the last hold cycle, `mux_y` is captured into shadow bit `sh[sel]`.
  - `sel` then increments, or the block enters DONE after channel 7.
- DONE behaviour:
  - `data` ← `sh` on entry, so `data` changes only when `valid` rises.
  - Next state is SCAN if `start`=1 (back-to-back scan, `sel`=0); otherwise IDLE.
- `start` while in SCAN is ignored; nothing is queued.
- `abort`=1 in SCAN:
  - Next state is IDLE with `sel`=0.
  - `sh` is discarded, `data` is unchanged, and no `valid` is produced.
- `abort` has priority over a sample or a completion in the same cycle. It is ignored in IDLE and DONE.
- Asynchronous reset, including during a scan:
  - State IDLE.
  - `sel`=0, `busy`=0, `valid`=0, `data`=0, `sh`=0, hold counter=0.

## Timing
- Sampling is same-cycle: `mux_y` is taken as valid in the same cycle `sel` is presented. With SETTLE=0, no cycle is spent settling.
- With `start` high in IDLE at edge e0:
  - SCAN occupies cycles 1..8·(SETTLE+1).
  - `valid` is high in cycle 8·(SETTLE+1)+1.
- Latency from `start` to `valid` is 9 cycles for SETTLE=0 and 17 cycles for SETTLE=1.
- Back-to-back scans with `start` held high give a throughput of one word per 8·(SETTLE+1)+1 cycles.
- All outputs are registered. `busy` falls in the same cycle that `valid` rises.

## Structure
- Shared package `mux_scan_pkg` contains:
  - NUM_CH=8 and SEL_W=3.
  - State encoding: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
- The hold counter is 4 bits wide and lives inline, not in a separate module.
- One sub-module is natural: the existing 8:1 multiplexer, instantiated only in the bench, with `sel`→{s2,s1,s0} and y→`mux_y`. The controller itself contains no multiplexer.

## Test plan
- Reset then idle:
  - Stimulus: `rst_n` low for 3 cycles, then high, no `start`.
  - Required: `sel`=0, `busy`=0, `valid`=0, `data`=8'h00 throughout.
- Basic scan, SETTLE=0:
  - Stimulus: mux inputs i7..i0=8'b1010_0110; one-cycle `start`.
  - Required: `sel` reads 0,1,…,7 on consecutive cycles; `valid` pulses exactly 9 cycles after `start`; `data`=8'hA6.
- Settle, SETTLE=2:
  - Stimulus: mux inputs 8'h3C; one-cycle `start`.
  - Required: each `sel` value is held 3 cycles; `valid` is high at cycle 25; `data`=8'h3C.
- Back-to-back:
  - Stimulus: `start` held high; mux inputs change from 8'h0F to 8'hF0 during DONE of the first scan.
  - Required: two `valid` pulses 9 cycles apart, with `data`=8'h0F and then 8'hF0; `busy` low for only the DONE cycle.
- Abort and ignored start:
  - Stimulus: complete one scan of 8'h55; start a scan of 8'hFF; assert `start` again at `sel`=2 (must be ignored); assert `abort` at `sel`=5.
  - Required: `sel`→0 and `busy`→0 on the next cycle; no `valid`; `data` stays 8'h55.
- Reset mid-scan:
  - Stimulus: drop `rst_n` asynchronously at `sel`=4.
  - Required: outputs clear immediately (`data`=8'h00); after release, a new `start` scans cleanly and produces the correct word.
